// File: rtl/button_conditioner.sv
// Push-button conditioner: synchronizer, debounce FSM, stable level and press/release strobes.
// Optional long-press detector enabled by defining BUTTON_CONDITIONER_LONG_PRESS_EN.
module button_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic ACT_LOW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    localparam logic [1:0] ST_IDLE        = 2'd0;
    localparam logic [1:0] ST_DEB_PRESS   = 2'd1;
    localparam logic [1:0] ST_HELD        = 2'd2;
    localparam logic [1:0] ST_DEB_RELEASE = 2'd3;

    if ((SYNC_STAGES < 2) || (DEBOUNCE_CYCLES < 2) || (LONG_CYCLES <= DEBOUNCE_CYCLES)) begin : g_bad_params
        $error("button_conditioner: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   btn_s;
    logic [1:0]             state_r;
    logic [1:0]             state_nxt_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       cnt_nxt_s;
    logic                   press_nxt_s;
    logic                   release_nxt_s;
    logic                   held_nxt_s;
    logic                   pressed_r;
    logic                   press_pulse_r;
    logic                   release_pulse_r;

    // Normalize polarity so that 1 always means the button is down.
    assign btn_s      = sync_r[SYNC_STAGES-1] ^ ACT_LOW;
    assign held_nxt_s = (state_nxt_s == ST_HELD) || (state_nxt_s == ST_DEB_RELEASE);

    // Debounce FSM next-state and strobe decode.
    always_comb begin
        state_nxt_s   = state_r;
        cnt_nxt_s     = cnt_r;
        press_nxt_s   = 1'b0;
        release_nxt_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (btn_s) begin
                    state_nxt_s = ST_DEB_PRESS;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_HELD;
                    cnt_nxt_s   = CNT_ZERO;
                    press_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (!btn_s) begin
                    state_nxt_s = ST_DEB_RELEASE;
                    cnt_nxt_s   = CNT_ONE;
                end else begin
                    cnt_nxt_s   = CNT_ZERO;
                end
            end
            ST_DEB_RELEASE: begin
                if (btn_s) begin
                    state_nxt_s   = ST_HELD;
                    cnt_nxt_s     = CNT_ZERO;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s   = ST_IDLE;
                    cnt_nxt_s     = CNT_ZERO;
                    release_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s     = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    // Synchronizer chain, FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r          <= {SYNC_STAGES{ACT_LOW}};
            state_r         <= ST_IDLE;
            cnt_r           <= CNT_ZERO;
            pressed_r       <= 1'b0;
            press_pulse_r   <= 1'b0;
            release_pulse_r <= 1'b0;
        end else begin
            sync_r          <= {sync_r[SYNC_STAGES-2:0], btn_raw};
            state_r         <= state_nxt_s;
            cnt_r           <= cnt_nxt_s;
            pressed_r       <= held_nxt_s;
            press_pulse_r   <= press_nxt_s;
            release_pulse_r <= release_nxt_s;
        end
    end

    assign pressed       = pressed_r;
    assign press_pulse   = press_pulse_r;
    assign release_pulse = release_pulse_r;

`ifdef BUTTON_CONDITIONER_LONG_PRESS_EN
    localparam int LONG_W = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_ZERO = {LONG_W{1'b0}};
    localparam logic [LONG_W-1:0] LONG_ONE  = LONG_W'(1);
    localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_cnt_r;
    logic [LONG_W-1:0] long_cnt_nxt_s;
    logic              long_press_r;

    // Hold-time counter: restarts on a fresh press, frozen while a release is being debounced.
    always_comb begin
        long_cnt_nxt_s = long_cnt_r;
        if ((state_r == ST_DEB_PRESS) && (state_nxt_s == ST_HELD)) begin
            long_cnt_nxt_s = LONG_ZERO;
        end else if (state_nxt_s == ST_IDLE) begin
            long_cnt_nxt_s = LONG_ZERO;
        end else if ((state_r == ST_HELD) && (long_cnt_r != LONG_MAX)) begin
            long_cnt_nxt_s = long_cnt_r + LONG_ONE;
        end else begin
            long_cnt_nxt_s = long_cnt_r;
        end
    end

    // Long counter and registered long_press level.
    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_r   <= LONG_ZERO;
            long_press_r <= 1'b0;
        end else begin
            long_cnt_r   <= long_cnt_nxt_s;
            long_press_r <= held_nxt_s && (long_cnt_nxt_s == LONG_MAX);
        end
    end

    assign long_press = long_press_r;
`else
    assign long_press = 1'b0;
`endif

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Cleans a raw mechanical push-button input (Mojo reset/user buttons).
- Synchronizes the input, debounces it, and reports the stable level plus single-cycle press and release pulses.
- Sits directly upstream of the reset pipeline stage: `pressed` drives that stage's `rst_in`, and the pulses feed the counter control logic.

Parameters:
- SYNC_STAGES, 2: number of synchronizer flops on `btn_raw`; must be ≥2.
- DEBOUNCE_CYCLES, 50000: consecutive cycles the synchronized input must hold a new value before it is accepted; must be ≥2.
- LONG_CYCLES, 50000000: cycles in HELD before `long_press` asserts; must be > DEBOUNCE_CYCLES. Used only with the optional feature.
- ACTIVE_LOW, 1: 1 means `btn_raw`=0 is pressed; 0 means `btn_raw`=1 is pressed.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- btn_raw  input  1  asynchronous raw button pin.
- pressed  output  1  debounced level; 1 = button held.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_press  output  1  level; 1 = held for at least LONG_CYCLES.

Behaviour:
- **Interface:** one clock, `clk`. Reset `rst` is synchronous and active-high.
- **Reset:**
  - While `rst`=1 at an edge, every synchronizer flop loads the released level (1 if ACTIVE_LOW, else 0).
  - Debounce counter = 0, long counter = 0, FSM = IDLE.
  - `pressed`, `press_pulse`, `release_pulse`, `long_press` are all 0.
- **Synchronizer:**
  - Input passes through a SYNC_STAGES-deep flop chain.
  - s = last flop, polarity-normalized so that 1 = pressed.
- **FSM states:** IDLE, DEB_PRESS, HELD, DEB_RELEASE. `pressed`=1 exactly in HELD and DEB_RELEASE.
- **IDLE:** s=1 → DEB_PRESS, with cnt ← 1.
- **DEB_PRESS:**
  - s=0 → IDLE, cnt ← 0 (bounce rejected; no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 → HELD, cnt ← 0, `press_pulse` ← 1 for one cycle.
  - Otherwise cnt ← cnt+1.
- **HELD:** s=0 → DEB_RELEASE, cnt ← 1.
- **DEB_RELEASE:**
  - Mirror of DEB_PRESS with polarity swapped.
  - s=1 → HELD, cnt ← 0 (no pulse).
  - Completion → IDLE with `release_pulse` for one cycle.
- **Latency:**
  - A clean raw edge arriving before clock edge 1 is accepted at edge SYNC_STAGES+DEBOUNCE_CYCLES.
  - After that edge, `pressed` toggles and the matching pulse is high for exactly that one cycle.
- **Pulse timing:** pulses are registered outputs, aligned with the cycle in which `pressed` changes.
- **Counter width:** `$clog2(DEBOUNCE_CYCLES)` bits. cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- **Bounce handling:** a bounce shorter than DEBOUNCE_CYCLES cycles produces no output change and restarts debounce from 1 on the next change.
- **Reset during HELD:**
  - Outputs drop to 0 on the reset edge; no `release_pulse` is generated.
  - If the button is still held after `rst` falls, it is treated as a new press and gets the full latency and a `press_pulse`.
- **Simultaneous events:** `rst` has priority over every transition and pulse.

Optional Feature:
- **Macro:** BUTTON_CONDITIONER_LONG_PRESS_EN.
- **Defined:**
  - A long counter (`$clog2(LONG_CYCLES+1)` bits) is cleared on entry to HELD and increments each cycle in HELD, saturating at LONG_CYCLES.
  - `long_press`=1 while in HELD or DEB_RELEASE with long counter == LONG_CYCLES.
  - The long counter holds its value in DEB_RELEASE; a bounce back to HELD does not clear it.
  - `long_press` clears with `pressed` on entry to IDLE, or on reset.
- **Not defined:** `long_press` is tied to 0 and no long counter is instantiated.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=16, ACTIVE_LOW=1):
1. **Reset:** `rst`=1 for 3 cycles with `btn_raw`=0 → all outputs 0 throughout. After `rst` falls, `btn_raw`=0 held gives `press_pulse` at edge 6 after release.
2. **Clean press:** `btn_raw` 1→0 before edge 1 and held → `pressed`=1 and `press_pulse`=1 after edge 6 only. `press_pulse`=0 after edge 7.
3. **Bounce rejection:** `btn_raw` low for 3 cycles, high 2, low 2, then high → `pressed` stays 0, no pulses.
4. **Release:** from HELD, `btn_raw` 0→1 held → `release_pulse` one cycle, `pressed`=0, both 6 edges after the change.
5. **Reset mid-hold:** `rst` pulse while `pressed`=1 and `btn_raw`=0 → `pressed` 0, no `release_pulse`. `press_pulse` fires 6 edges after `rst` deasserts.
6. **Long press** (macro defined): hold `btn_raw`=0 → `long_press`=1 exactly 16 edges after `press_pulse`. `long_press` falls together with `pressed` on release. Macro undefined → `long_press`=0 always.
